argmax_classify_fix8: RTL and testbench

//  Downstream controller for the fix8 sigmoid inference top. Launches one inference,

---
 rtl/argmax_classify_fix8.sv | 128 ++++++++++++
 tb/tb_argmax_classify_fix8.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classify_fix8.sv
// Launches one inference, waits for a fresh done, scans class scores and reports the signed argmax.
// Latency: start -> dnn_start next cycle; qualified done -> pred_valid NUM_CLASSES+1 cycles later.
// Backpressure: none; start is ignored while busy and is not queued.
module argmax_classify_fix8 #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_CLASSES    = 10,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         dnn_start,
    input  logic                         dnn_done,
    output logic [3:0]                   out_idx,
    input  logic signed [DATA_WIDTH-1:0] out_data,
    output logic [3:0]                   pred,
    output logic signed [DATA_WIDTH-1:0] pred_val,
    output logic                         pred_valid,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0] IDX_LAST = 4'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_SCAN,
        S_REPORT
    } state_t;

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   best;
    logic [3:0]                     best_idx;
    logic [TW-1:0]                  timer;
    logic                           done_low;
    logic signed [DATA_WIDTH-1:0]   cand_val;
    logic [3:0]                     cand_idx;

    // Running winner including the score on the bus this cycle; strict compare keeps the lowest index on ties.
    always_comb begin
        cand_val = best;
        cand_idx = best_idx;
        if ((out_idx == 4'd0) || (out_data > best)) begin
            cand_val = out_data;
            cand_idx = out_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            dnn_start   <= 1'b0;
            pred_valid  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            out_idx     <= 4'd0;
            pred        <= 4'd0;
            pred_val    <= '0;
            best        <= '0;
            best_idx    <= 4'd0;
            timer       <= '0;
            done_low    <= 1'b0;
        end else begin
            dnn_start  <= 1'b0;
            pred_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LAUNCH;
                        dnn_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    timeout_err <= 1'b0;
                    timer       <= '0;
                    done_low    <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level left over from the previous run only counts after it has been seen low.
                    if (done_low && dnn_done) begin
                        state   <= S_SCAN;
                        out_idx <= 4'd0;
                    end else if (TIMEOUT_EN && (timer == TIMER_LAST)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                        if (!dnn_done) begin
                            done_low <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    best     <= cand_val;
                    best_idx <= cand_idx;
                    if (out_idx == IDX_LAST) begin
                        // Result is published on entry so pred_valid coincides with the REPORT cycle.
                        state      <= S_REPORT;
                        out_idx    <= 4'd0;
                        pred       <= cand_idx;
                        pred_val   <= cand_val;
                        pred_valid <= 1'b1;
                    end else begin
                        out_idx <= out_idx + 4'd1;
                    end
                end
                S_REPORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    out_idx <= 4'd0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classify_fix8.sv
// Directed bench: score-table vectors through the full handshake, plus stale-done, timeout and reset sequences.
module tb_argmax_classify_fix8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dnn_start;
    logic        dnn_done;
    logic [3:0]  out_idx;
    logic [7:0]  out_data;
    logic [3:0]  pred;
    logic [7:0]  pred_val;
    logic        pred_valid;
    logic        busy;
    logic        timeout_err;

    logic        t_start;
    logic        t_dnn_start;
    logic        t_dnn_done;
    logic [3:0]  t_out_idx;
    logic [7:0]  t_out_data;
    logic [3:0]  t_pred;
    logic [7:0]  t_pred_val;
    logic        t_pred_valid;
    logic        t_busy;
    logic        t_timeout_err;

    logic [7:0]  sc_mem [16];
    int          checks = 0;
    int          failures = 0;
    int          ds_cnt = 0;

    always #5 clk = ~clk;

    assign out_data   = sc_mem[out_idx];
    assign t_out_data = 8'd0;

    argmax_classify_fix8 u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dnn_start   (dnn_start),
        .dnn_done    (dnn_done),
        .out_idx     (out_idx),
        .out_data    (out_data),
        .pred        (pred),
        .pred_val    (pred_val),
        .pred_valid  (pred_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    argmax_classify_fix8 #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk         (clk),
        .rst         (rst),
        .start       (t_start),
        .dnn_start   (t_dnn_start),
        .dnn_done    (t_dnn_done),
        .out_idx     (t_out_idx),
        .out_data    (t_out_data),
        .pred        (t_pred),
        .pred_val    (t_pred_val),
        .pred_valid  (t_pred_valid),
        .busy        (t_busy),
        .timeout_err (t_timeout_err)
    );

    always @(negedge clk) if (dnn_start) ds_cnt++;

    typedef struct {
        logic [9:0][7:0] sc;
        logic [3:0]      exp_pred;
        logic [7:0]      exp_val;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input int v);
        for (int i = 0; i < 16; i++) sc_mem[i] = (i < 10) ? vecs[v].sc[i] : 8'h00;
    endtask

    // One classification: done held stale-high for `hold` cycles after launch, low for `dly` cycles, then high.
    task automatic do_run(input string tag, input int hold, input int dly,
                          input logic [3:0] ep, input logic [7:0] ev);
        int  k;
        bit  seen;
        bit  idle_ok;
        bit  scan_ok;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_dnn_start"}, dnn_start, 1);
        check({tag, "_busy"}, busy, 1);
        idle_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_idx != 4'd0 || pred_valid || !busy) idle_ok = 1'b0;
        end
        dnn_done = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (out_idx != 4'd0 || pred_valid || !busy) idle_ok = 1'b0;
        end
        check({tag, "_wait_idle"}, idle_ok, 1);
        dnn_done = 1'b1;
        k = 0;
        seen = 1'b0;
        scan_ok = 1'b1;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (k <= 10 && out_idx != 4'(k - 1)) scan_ok = 1'b0;
            if (pred_valid) seen = 1'b1;
        end
        check({tag, "_scan_idx"}, scan_ok, 1);
        check({tag, "_pv_latency"}, k, 11);
        check({tag, "_pred"}, pred, ep);
        check({tag, "_pred_val"}, pred_val, ev);
        @(negedge clk);
        check({tag, "_pv_pulse"}, pred_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int  n;
        int  pv_cnt;
        int  ds0;
        bit  pv_seen;

        for (int i = 0; i < 10; i++) begin
            vecs[0].sc[i] = 8'hEC;
            vecs[1].sc[i] = 8'h00;
            vecs[2].sc[i] = 8'h80;
            vecs[3].sc[i] = 8'h05;
            vecs[4].sc[i] = 8'hFF;
            vecs[5].sc[i] = 8'(i * 10);
        end
        vecs[0].sc[3] = 8'd100;  vecs[0].exp_pred = 4'd3; vecs[0].exp_val = 8'd100;
        vecs[1].sc[2] = 8'd50;   vecs[1].sc[7] = 8'd50;
        vecs[1].exp_pred = 4'd2; vecs[1].exp_val = 8'd50;
        vecs[2].sc[9] = 8'h81;   vecs[2].exp_pred = 4'd9; vecs[2].exp_val = 8'h81;
        vecs[3].exp_pred = 4'd0; vecs[3].exp_val = 8'h05;
        vecs[4].sc[0] = 8'h80;   vecs[4].sc[6] = 8'h7F;
        vecs[4].exp_pred = 4'd6; vecs[4].exp_val = 8'h7F;
        vecs[5].sc[0] = 8'h7F;   vecs[5].exp_pred = 4'd0; vecs[5].exp_val = 8'h7F;

        rst = 1'b0; start = 1'b0; dnn_done = 1'b1; t_start = 1'b0; t_dnn_done = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dnn_start", dnn_start, 0);
        check("rst_pred_valid", pred_valid, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_pred", pred, 0);
        check("rst_pred_val", pred_val, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_t_busy", t_busy, 0);
        rst = 1'b1;

        for (int v = 0; v < 6; v++) begin
            load(v);
            do_run($sformatf("vec%0d", v), 1, 3, vecs[v].exp_pred, vecs[v].exp_val);
        end

        // Stale done high through the first WAIT cycles, long low phase.
        load(1);
        do_run("stale", 3, 40, vecs[1].exp_pred, vecs[1].exp_val);

        // Timeout instance: done never rises.
        @(negedge clk); t_start = 1'b1;
        @(negedge clk); t_start = 1'b0;
        check("to_dnn_start", t_dnn_start, 1);
        n = 0;
        pv_seen = 1'b0;
        while (t_busy && n < 40) begin
            @(negedge clk);
            n++;
            if (t_pred_valid) pv_seen = 1'b1;
        end
        check("to_busy_cycles", n, 17);
        check("to_err", t_timeout_err, 1);
        check("to_busy", t_busy, 0);
        check("to_no_pv", pv_seen, 0);
        check("to_pred", t_pred, 0);
        repeat (3) @(negedge clk);
        check("to_err_sticky", t_timeout_err, 1);
        @(negedge clk); t_start = 1'b1;
        @(negedge clk); t_start = 1'b0;
        @(negedge clk);
        check("to_err_cleared", t_timeout_err, 0);
        check("to_rerun_busy", t_busy, 1);

        // Reset in the middle of SCAN.
        load(0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); dnn_done = 1'b0;
        repeat (3) @(negedge clk);
        dnn_done = 1'b1;
        n = 0;
        while (out_idx != 4'd5 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_idx5", out_idx, 5);
        rst = 1'b0;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_out_idx", out_idx, 0);
        check("mid_pred", pred, 0);
        check("mid_pred_val", pred_val, 0);
        check("mid_pred_valid", pred_valid, 0);
        rst = 1'b1;
        pv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (pred_valid) pv_cnt++;
        end
        check("mid_no_pv_after", pv_cnt, 0);

        // Start pulses while busy must not queue a second run.
        ds0 = ds_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); dnn_done = 1'b0; start = 1'b1;
        @(negedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk); dnn_done = 1'b1;
        n = 0;
        pv_seen = 1'b0;
        while (!pv_seen && n < 30) begin
            @(negedge clk);
            n++;
            start = (n == 4);
            if (pred_valid) pv_seen = 1'b1;
        end
        start = 1'b0;
        check("busy_start_pv", pv_seen, 1);
        check("busy_start_pred", pred, 3);
        repeat (10) @(negedge clk);
        check("busy_start_launches", ds_cnt - ds0, 1);
        check("busy_start_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
